// File: rtl/rob_retire.sv
// -----------------------------------------------------------------------------
// rob_retire
//
// 16-entry circular reorder buffer. Dispatch allocates up to two entries per
// cycle at the tail, three functional units mark entries done by ROB index,
// and up to two completed entries retire per cycle from the head, in program
// order. At most one store retires per cycle.
//
// Optional feature macro: ROB_COMPLETE_BYPASS_EN
//   defined   : retire select also treats an entry as done if a completion for
//               it arrives in the same cycle, and takes data from that port
//               (1-cycle complete->retire).
//   undefined : only stored done bits are used (2-cycle complete->retire).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alloc_valid_1/2          allocate request, slot 1 then slot 2
//   alloc_rd/pd/old_pd/store_1/2  fields of the allocated entries
//   alloc_ready              at least two entries free
//   alloc_idx_1/2            tail and tail+1 (combinational)
//   complete_valid/rob/data_1..3  FU results, addressed by ROB index
//   retire_valid_1/2         registered retire strobes, oldest first
//   retire_rd/pd/old_pd/data/store_1/2  fields of the retired entries
//   count, empty, full       occupancy
// -----------------------------------------------------------------------------
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic [AREG_W-1:0] alloc_rd_1,
  input  logic [AREG_W-1:0] alloc_rd_2,
  input  logic [PREG_W-1:0] alloc_pd_1,
  input  logic [PREG_W-1:0] alloc_pd_2,
  input  logic [PREG_W-1:0] alloc_old_pd_1,
  input  logic [PREG_W-1:0] alloc_old_pd_2,
  input  logic              alloc_store_1,
  input  logic              alloc_store_2,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_idx_1,
  output logic [PTR_W-1:0]  alloc_idx_2,

  input  logic              complete_valid_1,
  input  logic [PTR_W-1:0]  complete_rob_1,
  input  logic [DATA_W-1:0] complete_data_1,
  input  logic              complete_valid_2,
  input  logic [PTR_W-1:0]  complete_rob_2,
  input  logic [DATA_W-1:0] complete_data_2,
  input  logic              complete_valid_3,
  input  logic [PTR_W-1:0]  complete_rob_3,
  input  logic [DATA_W-1:0] complete_data_3,

  output logic              retire_valid_1,
  output logic [AREG_W-1:0] retire_rd_1,
  output logic [PREG_W-1:0] retire_pd_1,
  output logic [PREG_W-1:0] retire_old_pd_1,
  output logic [DATA_W-1:0] retire_data_1,
  output logic              retire_store_1,
  output logic              retire_valid_2,
  output logic [AREG_W-1:0] retire_rd_2,
  output logic [PREG_W-1:0] retire_pd_2,
  output logic [PREG_W-1:0] retire_old_pd_2,
  output logic [DATA_W-1:0] retire_data_2,
  output logic              retire_store_2,

  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam int             NCMP      = 3;
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);

  // Entry control bits (reset) and payload (not reset).
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [DEPTH-1:0]  ent_store;
  logic [AREG_W-1:0] ent_rd     [DEPTH];
  logic [PREG_W-1:0] ent_pd     [DEPTH];
  logic [PREG_W-1:0] ent_old_pd [DEPTH];
  logic [DATA_W-1:0] ent_data   [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  head_nx;
  logic [PTR_W-1:0]  tail_nx;
  logic [PTR_W:0]    cnt;

  // Completion ports gathered into arrays so they can be walked in k order.
  logic              cmp_valid [NCMP];
  logic [PTR_W-1:0]  cmp_rob   [NCMP];
  logic [DATA_W-1:0] cmp_data  [NCMP];

  assign cmp_valid[0] = complete_valid_1;
  assign cmp_valid[1] = complete_valid_2;
  assign cmp_valid[2] = complete_valid_3;
  assign cmp_rob[0]   = complete_rob_1;
  assign cmp_rob[1]   = complete_rob_2;
  assign cmp_rob[2]   = complete_rob_3;
  assign cmp_data[0]  = complete_data_1;
  assign cmp_data[1]  = complete_data_2;
  assign cmp_data[2]  = complete_data_3;

  // Pointers wrap for free because DEPTH is a power of two.
  assign head_nx = head + PTR_W'(1);
  assign tail_nx = tail + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Allocation acceptance. alloc_ready looks only at the current count, so a
  // retire in the same cycle never frees a slot for that cycle's dispatch.
  // ---------------------------------------------------------------------------
  logic       alloc_acc_1;
  logic       alloc_acc_2;
  logic [1:0] n_alloc;

  assign alloc_ready = (cnt <= READY_MAX);
  assign alloc_idx_1 = tail;
  assign alloc_idx_2 = tail_nx;
  assign alloc_acc_1 = alloc_ready & alloc_valid_1;
  assign alloc_acc_2 = alloc_acc_1 & alloc_valid_2;
  assign n_alloc     = {1'b0, alloc_acc_1} + {1'b0, alloc_acc_2};

  // ---------------------------------------------------------------------------
  // Retire select: effective done/data for the two oldest entries.
  // ---------------------------------------------------------------------------
  logic              head_done;
  logic              next_done;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] next_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    head_done = ent_done[head];
    head_data = ent_data[head];
    next_done = ent_done[head_nx];
    next_data = ent_data[head_nx];
`ifdef ROB_COMPLETE_BYPASS_EN
    // Ascending k so the highest-numbered matching port supplies the data.
    for (int k = 0; k < NCMP; k++) begin
      if (cmp_valid[k] && (cmp_rob[k] == head)) begin
        head_done = 1'b1;
        head_data = cmp_data[k];
      end
      if (cmp_valid[k] && (cmp_rob[k] == head_nx)) begin
        next_done = 1'b1;
        next_data = cmp_data[k];
      end
    end
`endif
  end

  logic       ret_1;
  logic       ret_2;
  logic [1:0] n_ret;

  // Second slot requires the first, and two stores never retire together.
  assign ret_1 = ent_valid[head] & head_done;
  assign ret_2 = ret_1 & ent_valid[head_nx] & next_done
               & ~(ent_store[head] & ent_store[head_nx]);
  assign n_ret = {1'b0, ret_1} + {1'b0, ret_2};

  // ---------------------------------------------------------------------------
  // Control state: valid/done bits, pointers, count, retire outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid       <= '0;
      ent_done        <= '0;
      head            <= '0;
      tail            <= '0;
      cnt             <= '0;
      retire_valid_1  <= 1'b0;
      retire_rd_1     <= '0;
      retire_pd_1     <= '0;
      retire_old_pd_1 <= '0;
      retire_data_1   <= '0;
      retire_store_1  <= 1'b0;
      retire_valid_2  <= 1'b0;
      retire_rd_2     <= '0;
      retire_pd_2     <= '0;
      retire_old_pd_2 <= '0;
      retire_data_2   <= '0;
      retire_store_2  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates; when several statements below target the
      // same bit, the last one in program order wins (complete, then
      // allocate, then retire-clear).
      for (int k = 0; k < NCMP; k++) begin
        if (cmp_valid[k] && ent_valid[cmp_rob[k]]) begin
          ent_done[cmp_rob[k]] <= 1'b1;
        end
      end

      if (alloc_acc_1) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
      end
      if (alloc_acc_2) begin
        ent_valid[tail_nx] <= 1'b1;
        ent_done[tail_nx]  <= 1'b0;
      end

      if (ret_1) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
      end
      if (ret_2) begin
        ent_valid[head_nx] <= 1'b0;
        ent_done[head_nx]  <= 1'b0;
      end

      head <= head + PTR_W'(n_ret);
      tail <= tail + PTR_W'(n_alloc);
      cnt  <= cnt + (PTR_W+1)'(n_alloc) - (PTR_W+1)'(n_ret);

      retire_valid_1 <= ret_1;
      retire_valid_2 <= ret_2;
      if (ret_1) begin
        retire_rd_1     <= ent_rd[head];
        retire_pd_1     <= ent_pd[head];
        retire_old_pd_1 <= ent_old_pd[head];
        retire_data_1   <= head_data;
        retire_store_1  <= ent_store[head];
      end
      if (ret_2) begin
        retire_rd_2     <= ent_rd[head_nx];
        retire_pd_2     <= ent_pd[head_nx];
        retire_old_pd_2 <= ent_old_pd[head_nx];
        retire_data_2   <= next_data;
        retire_store_2  <= ent_store[head_nx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage.
  // ---------------------------------------------------------------------------
  // NOTE: the payload arrays carry no reset; an entry's fields are only ever
  // read while its valid bit is set, and valid is always written with them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCMP; k++) begin
      if (cmp_valid[k] && ent_valid[cmp_rob[k]]) begin
        ent_data[cmp_rob[k]] <= cmp_data[k];
      end
    end
    if (alloc_acc_1) begin
      ent_rd[tail]     <= alloc_rd_1;
      ent_pd[tail]     <= alloc_pd_1;
      ent_old_pd[tail] <= alloc_old_pd_1;
      ent_store[tail]  <= alloc_store_1;
    end
    if (alloc_acc_2) begin
      ent_rd[tail_nx]     <= alloc_rd_2;
      ent_pd[tail_nx]     <= alloc_pd_2;
      ent_old_pd[tail_nx] <= alloc_old_pd_2;
      ent_store[tail_nx]  <= alloc_store_2;
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

endmodule

// File: tb/tb_rob_retire.sv
// -----------------------------------------------------------------------------
// tb_rob_retire
//
// Scoreboard bench for rob_retire. Every accepted allocation pushes its
// expected retire record (fields plus the data the bench will later complete
// it with); every observed retire strobe pops and compares in program order.
// A small occupancy model tracks count/empty/full/alloc_ready/alloc_idx.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rob_retire;

`ifdef ROB_COMPLETE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [5:0]  old_pd;
    logic        st;
    logic [31:0] data;
  } ret_t;

  logic        clk;
  logic        rst;
  logic        alloc_valid_1, alloc_valid_2;
  logic [4:0]  alloc_rd_1, alloc_rd_2;
  logic [5:0]  alloc_pd_1, alloc_pd_2;
  logic [5:0]  alloc_old_pd_1, alloc_old_pd_2;
  logic        alloc_store_1, alloc_store_2;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        complete_valid_1, complete_valid_2, complete_valid_3;
  logic [3:0]  complete_rob_1, complete_rob_2, complete_rob_3;
  logic [31:0] complete_data_1, complete_data_2, complete_data_3;
  logic        retire_valid_1, retire_valid_2;
  logic [4:0]  retire_rd_1, retire_rd_2;
  logic [5:0]  retire_pd_1, retire_pd_2;
  logic [5:0]  retire_old_pd_1, retire_old_pd_2;
  logic [31:0] retire_data_1, retire_data_2;
  logic        retire_store_1, retire_store_2;
  logic [4:0]  count;
  logic        empty, full;

  rob_retire dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid_1    (alloc_valid_1),
    .alloc_valid_2    (alloc_valid_2),
    .alloc_rd_1       (alloc_rd_1),
    .alloc_rd_2       (alloc_rd_2),
    .alloc_pd_1       (alloc_pd_1),
    .alloc_pd_2       (alloc_pd_2),
    .alloc_old_pd_1   (alloc_old_pd_1),
    .alloc_old_pd_2   (alloc_old_pd_2),
    .alloc_store_1    (alloc_store_1),
    .alloc_store_2    (alloc_store_2),
    .alloc_ready      (alloc_ready),
    .alloc_idx_1      (alloc_idx_1),
    .alloc_idx_2      (alloc_idx_2),
    .complete_valid_1 (complete_valid_1),
    .complete_rob_1   (complete_rob_1),
    .complete_data_1  (complete_data_1),
    .complete_valid_2 (complete_valid_2),
    .complete_rob_2   (complete_rob_2),
    .complete_data_2  (complete_data_2),
    .complete_valid_3 (complete_valid_3),
    .complete_rob_3   (complete_rob_3),
    .complete_data_3  (complete_data_3),
    .retire_valid_1   (retire_valid_1),
    .retire_rd_1      (retire_rd_1),
    .retire_pd_1      (retire_pd_1),
    .retire_old_pd_1  (retire_old_pd_1),
    .retire_data_1    (retire_data_1),
    .retire_store_1   (retire_store_1),
    .retire_valid_2   (retire_valid_2),
    .retire_rd_2      (retire_rd_2),
    .retire_pd_2      (retire_pd_2),
    .retire_old_pd_2  (retire_old_pd_2),
    .retire_data_2    (retire_data_2),
    .retire_store_2   (retire_store_2),
    .count            (count),
    .empty            (empty),
    .full             (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  ret_t        exp_q  [$];
  logic [3:0]  pend_q [$];
  logic [31:0] mdata  [16];
  int          mcnt;
  logic [3:0]  mtail;
  int          n_acc;
  int          last_ret;

  task automatic drive_idle();
    alloc_valid_1    = 1'b0;
    alloc_valid_2    = 1'b0;
    alloc_rd_1       = '0;
    alloc_rd_2       = '0;
    alloc_pd_1       = '0;
    alloc_pd_2       = '0;
    alloc_old_pd_1   = '0;
    alloc_old_pd_2   = '0;
    alloc_store_1    = 1'b0;
    alloc_store_2    = 1'b0;
    complete_valid_1 = 1'b0;
    complete_valid_2 = 1'b0;
    complete_valid_3 = 1'b0;
    complete_rob_1   = '0;
    complete_rob_2   = '0;
    complete_rob_3   = '0;
    complete_data_1  = '0;
    complete_data_2  = '0;
    complete_data_3  = '0;
  endtask

  // One clock: sample #1 after the edge, score retires, update the occupancy
  // model, then return inputs to idle for the next cycle.
  task automatic tick();
    ret_t obs [2];
    logic rv  [2];
    ret_t e;
    @(posedge clk);
    #1;
    rv[0]  = retire_valid_1;
    rv[1]  = retire_valid_2;
    obs[0] = {retire_rd_1, retire_pd_1, retire_old_pd_1, retire_store_1, retire_data_1};
    obs[1] = {retire_rd_2, retire_pd_2, retire_old_pd_2, retire_store_2, retire_data_2};
    last_ret = 0;
    n_cmp++;
    if (rv[1] && !rv[0]) begin
      n_bad++;
      $display("FAIL retire_pair t=%0t: retire_valid_2=1 while retire_valid_1=0, required slot 2 only with slot 1", $time);
    end
    for (int j = 0; j < 2; j++) begin
      if (rv[j]) begin
        last_ret++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL retire_unexpected t=%0t slot %0d: got %h, required no retire", $time, j + 1, obs[j]);
        end else begin
          e = exp_q.pop_front();
          if (obs[j] !== e) begin
            n_bad++;
            $display("FAIL retire_fields t=%0t slot %0d: got rd=%0d pd=%0d old=%0d st=%0b data=%h, required rd=%0d pd=%0d old=%0d st=%0b data=%h",
                     $time, j + 1, obs[j].rd, obs[j].pd, obs[j].old_pd, obs[j].st, obs[j].data,
                     e.rd, e.pd, e.old_pd, e.st, e.data);
          end
        end
      end
    end
    mcnt  = mcnt + n_acc - last_ret;
    n_acc = 0;
    n_cmp++;
    if (count !== 5'(mcnt)) begin
      n_bad++;
      $display("FAIL count t=%0t: got %0d, required %0d", $time, count, mcnt);
    end
    n_cmp++;
    if (empty !== (mcnt == 0) || full !== (mcnt == 16)) begin
      n_bad++;
      $display("FAIL empty_full t=%0t: got empty=%0b full=%0b, required empty=%0b full=%0b",
               $time, empty, full, (mcnt == 0), (mcnt == 16));
    end
    drive_idle();
  endtask

  // Drive one cycle of allocation request; pushes the expected records for
  // whatever the model says will be accepted.
  task automatic do_alloc(input logic v1, input logic v2, input logic s1, input logic s2,
                          input logic [5:0] p1, input logic [5:0] p2,
                          input logic [31:0] d1, input logic [31:0] d2);
    logic       ok;
    logic [3:0] t2;
    ret_t       e;
    ok = (mcnt <= 14);
    t2 = mtail + 4'd1;
    n_cmp++;
    if (alloc_ready !== ok) begin
      n_bad++;
      $display("FAIL alloc_ready t=%0t: got %0b, required %0b (count %0d)", $time, alloc_ready, ok, mcnt);
    end
    n_cmp++;
    if (alloc_idx_1 !== mtail || alloc_idx_2 !== t2) begin
      n_bad++;
      $display("FAIL alloc_idx t=%0t: got %0d/%0d, required %0d/%0d", $time, alloc_idx_1, alloc_idx_2, mtail, t2);
    end
    alloc_valid_1  = v1;
    alloc_valid_2  = v2;
    alloc_rd_1     = 5'($urandom);
    alloc_rd_2     = 5'($urandom);
    alloc_pd_1     = p1;
    alloc_pd_2     = p2;
    alloc_old_pd_1 = 6'($urandom);
    alloc_old_pd_2 = 6'($urandom);
    alloc_store_1  = s1;
    alloc_store_2  = s2;
    if (ok && v1) begin
      e = {alloc_rd_1, p1, alloc_old_pd_1, s1, d1};
      exp_q.push_back(e);
      pend_q.push_back(mtail);
      mdata[mtail] = d1;
      mtail = mtail + 4'd1;
      n_acc++;
      if (v2) begin
        e = {alloc_rd_2, p2, alloc_old_pd_2, s2, d2};
        exp_q.push_back(e);
        pend_q.push_back(mtail);
        mdata[mtail] = d2;
        mtail = mtail + 4'd1;
        n_acc++;
      end
    end
  endtask

  task automatic set_cmp(input int k, input logic [3:0] idx, input logic [31:0] d);
    case (k)
      1: begin complete_valid_1 = 1'b1; complete_rob_1 = idx; complete_data_1 = d; end
      2: begin complete_valid_2 = 1'b1; complete_rob_2 = idx; complete_data_2 = d; end
      default: begin complete_valid_3 = 1'b1; complete_rob_3 = idx; complete_data_3 = d; end
    endcase
  endtask

  task automatic complete_some();
    logic [3:0] idx;
    for (int k = 1; k <= 3; k++) begin
      if (pend_q.size() > 0) begin
        idx = pend_q.pop_front();
        set_cmp(k, idx, mdata[idx]);
      end
    end
  endtask

  task automatic finish_all();
    int guard;
    guard = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      complete_some();
      tick();
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout t=%0t: %0d entries never retired, required 0", $time, exp_q.size());
    end
  endtask

  task automatic check_ret(input string name, input int want);
    n_cmp++;
    if (last_ret !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d retires, required %0d", name, $time, last_ret, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    mcnt  = 0;
    mtail = '0;
    n_acc = 0;
    drive_idle();
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_occupancy: got count=%0d empty=%0b full=%0b ready=%0b, required 0/1/0/1",
               count, empty, full, alloc_ready);
    end
    n_cmp++;
    if (retire_valid_1 !== 1'b0 || retire_valid_2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_retire: got %0b/%0b, required 0/0", retire_valid_1, retire_valid_2);
    end
    n_cmp++;
    if (alloc_idx_1 !== 4'd0 || alloc_idx_2 !== 4'd1) begin
      n_bad++;
      $display("FAIL reset_idx: got %0d/%0d, required 0/1", alloc_idx_1, alloc_idx_2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    do_reset();
    repeat (2) tick();
  endtask

  task automatic test_dual_complete();
    logic [3:0] i0;
    i0 = mtail;
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd33, 6'd34, 32'h5, 32'hA);
    tick();
    pend_q.delete();
    set_cmp(1, i0, 32'h5);
    set_cmp(3, i0 + 4'd1, 32'hA);
    tick();
    check_ret("dual_at_complete_edge", BYP ? 2 : 0);
    tick();
    check_ret("dual_one_later", BYP ? 0 : 2);
  endtask

  task automatic test_out_of_order();
    logic [3:0] i0;
    i0 = mtail;
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd10, 6'd11, 32'h1111_0000, 32'h2222_0000);
    set_cmp(2, i0, 32'hDEAD_BEEF);  // same cycle as allocation: must be ignored
    tick();
    pend_q.delete();
    tick();
    check_ret("ooo_same_cycle_ignored", 0);
    set_cmp(1, i0 + 4'd1, 32'h2222_0000);
    tick();
    check_ret("ooo_younger_only_a", 0);
    tick();
    check_ret("ooo_younger_only_b", 0);
    set_cmp(1, i0, 32'h1111_0000);
    tick();
    check_ret("ooo_oldest_edge", BYP ? 2 : 0);
    tick();
    check_ret("ooo_both_retire", BYP ? 0 : 2);
  endtask

  task automatic test_fill_wrap();
    do_alloc(1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 6'd2, 32'h0, 32'h0);  // slot 2 alone ignored
    tick();
    for (int i = 0; i < 7; i++) begin
      do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'($urandom), 6'($urandom), $urandom, $urandom);
      tick();
    end
    do_alloc(1'b1, 1'b0, 1'b0, 1'b0, 6'($urandom), 6'd0, $urandom, 32'h0);
    tick();
    do_alloc(1'b1, 1'b0, 1'b0, 1'b0, 6'd63, 6'd0, 32'hBAD0_BAD0, 32'h0);  // dropped at 15
    tick();
    finish_all();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'($urandom), 6'($urandom), $urandom, $urandom);
      tick();
    end
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd62, 6'd61, 32'h0, 32'h0);  // dropped at 16
    tick();
    finish_all();
  endtask

  task automatic test_stores();
    logic [3:0] i0;
    i0 = mtail;
    do_alloc(1'b1, 1'b1, 1'b1, 1'b1, 6'd20, 6'd21, 32'h5707_0001, 32'h5707_0002);
    tick();
    pend_q.delete();
    set_cmp(2, i0, 32'h5707_0001);
    set_cmp(3, i0 + 4'd1, 32'h5707_0002);
    tick();
    check_ret("store_edge_a", BYP ? 1 : 0);
    tick();
    check_ret("store_edge_b", 1);
    tick();
    check_ret("store_edge_c", BYP ? 0 : 1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] i0;
    i0 = mtail;
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd40, 6'd41, 32'hAAAA_0001, 32'hAAAA_0002);
    tick();
    pend_q.delete();
    set_cmp(1, i0, ~mdata[i0]);          // lower port loses to port 3
    set_cmp(2, i0 + 4'd1, mdata[i0 + 4'd1]);
    set_cmp(3, i0, mdata[i0]);
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd42, 6'd43, 32'hBBBB_0001, 32'hBBBB_0002);
    tick();
    check_ret("b2b_edge_m", BYP ? 2 : 0);
    complete_some();
    tick();
    check_ret("b2b_edge_m1", 2);
    finish_all();
  endtask

  task automatic test_reset_inflight();
    logic [3:0] i0;
    i0 = mtail;
    for (int i = 0; i < 3; i++) begin
      do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'($urandom), 6'($urandom), $urandom, $urandom);
      tick();
    end
    pend_q.delete();
    set_cmp(1, i0, mdata[i0]);
    set_cmp(2, i0 + 4'd1, mdata[i0 + 4'd1]);
    tick();
    set_cmp(3, i0 + 4'd2, mdata[i0 + 4'd2]);  // in flight at the reset edge
    do_reset();
    repeat (3) tick();
    do_alloc(1'b1, 1'b1, 1'b0, 1'b0, 6'd50, 6'd51, 32'hC0DE_0001, 32'hC0DE_0002);
    tick();
    finish_all();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mcnt  = 0;
    mtail = '0;
    n_acc = 0;
    last_ret = 0;
    test_reset();
    test_dual_complete();
    test_out_of_order();
    test_fill_wrap();
    test_full();
    test_stores();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
